ov7670_capture: RTL
===================

# ov7670_capture

Write-side front end of the camera-to-VGA path. Samples the OV7670 parallel bus (VSYNC/HREF/D[7:0], RGB565, two bytes per pixel) in the camera pixel-clock domain and packs each pixel to RGB444. Each packed pixel is presented as a single-cycle write strobe plus 12-bit word to the async FIFO write port. The block also frames capture to whole frames, checks line and frame geometry, and flags pixels dropped on FIFO full.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line (HREF-high pixel count)
- V_ACTIVE, 480, lines per frame
- CNT_W, 10, width of pixel and line counters; must satisfy 2^CNT_W > max(H_ACTIVE, V_ACTIVE)

Ports:
- wclk  in  1  camera PCLK; all logic on rising edge
- wrst  in  1  asynchronous, active-high reset
- cap_en  in  1  capture enable; sampled only at frame boundaries
- vsync  in  1  camera VSYNC, active high during vertical blank
- href  in  1  camera HREF, high during active line bytes
- d  in  8  camera data byte
- full  in  1  FIFO full, already synchronised into wclk
- w_en  out  1  FIFO write strobe, one cycle per accepted pixel
- data_in  out  12  packed pixel {R[3:0],G[3:0],B[3:0]}
- sof  out  1  one-cycle pulse on entering CAPTURE
- frame_done  out  1  one-cycle pulse when a captured frame ends
- overflow  out  1  sticky: a pixel was dropped because full=1
- line_err  out  1  sticky: a line ended with a pixel count not equal to H_ACTIVE, or on an odd byte
- frame_err  out  1  sticky: a frame ended with a line count not equal to V_ACTIVE

## Operation
- FSM states are IDLE, WAIT_FRAME and CAPTURE.
  - IDLE: no writes. Go to WAIT_FRAME when vsync=1. This guarantees a frame is never entered mid-stream.
  - WAIT_FRAME: on the edge where vsync=0 and cap_en=1, go to CAPTURE and pulse sof. If cap_en=0, stay in WAIT_FRAME.
  - CAPTURE: assemble pixels while href=1. When vsync=1 is seen, pulse frame_done, evaluate frame_err, and go to WAIT_FRAME.
- Deasserting cap_en mid-frame has no effect until the frame ends.
- Byte phase toggle `ph`:
  - Cleared on entering CAPTURE and on every href falling edge.
  - On each edge in CAPTURE with href=1: if ph=0, latch d into b1 and set ph=1. If ph=1, pack the pixel and set ph=0.
- Packing: data_in = {b1[7:4], b1[2:0], d[7], d[4:1]}. This takes the top 4 bits of R5, G6 and B5.
- Write rule: a pixel completes (ph=1, href=1).
  - If full=0: w_en=1 next cycle.
  - If full=1: w_en stays 0 and overflow is set.
  - The pixel counter increments in both cases.
- Pixel counter: reset to 0 on href falling edge. Width is CNT_W; it saturates at 2^CNT_W−1 and never wraps.
- Line end (href 1→0 in CAPTURE):
  - Set line_err if pixel count ≠ H_ACTIVE or ph=1.
  - Then increment the line counter, which saturates.
  - The line counter is cleared on entering CAPTURE.
- Frame end: set frame_err if line count ≠ V_ACTIVE.
- Sticky flags (overflow, line_err, frame_err) clear only on wrst.
- The href edge is detected against href_q, a registered copy of href. href_q resets to 0.

## Timing
- Reset values: state=IDLE; w_en=0, data_in=0, sof=0, frame_done=0, all flags=0; ph=0, counters=0.
- Reset is asynchronous. An assertion mid-line aborts immediately with no partial write. After release, the block re-enters via IDLE and waits for a full VSYNC pulse.
- Latency: the second byte is sampled at edge k; w_en and data_in are valid from edge k to edge k+1. data_in holds its value when w_en=0.
- full is sampled at edge k only. A full that rises in the w_en cycle is the FIFO's responsibility.
- sof is registered at the edge where vsync=0 is observed in WAIT_FRAME. frame_done is registered at the edge where vsync=1 is observed in CAPTURE.
- Simultaneous events:
  - vsync rising while href=1: frame end takes priority. The line is closed, line_err is evaluated, and a pending pixel with ph=1 is written only if it completed on that edge.
  - A pixel that completes on the href-fall edge cannot occur, because href=0 on that edge.
- Sustained throughput is one pixel per two wclk. w_en is never high on two consecutive cycles.

## Test plan
- Sim parameters: H_ACTIVE=4, V_ACTIVE=2. Send byte pairs F8/00, 07/E0, 00/1F, FF/FF. Required: w_en pulses carry 0xF00, 0x0F0, 0x00F, 0xFFF in that order, 2 cycles apart, with a 1-cycle latency from the second byte.
- Full frame of 2 lines × 4 pixels, cap_en=1. Required: 8 writes, one sof and one frame_done, no flags set.
- Hold full=1 during pixels 2–3 of line 0. Required: those 2 writes are suppressed, overflow=1 and stays set, and the remaining 6 pixels are written.
- Line 1 carries 3 pixels, and a separate line carries 9 bytes. Required: line_err=1 and frame_err stays 0. A frame with 3 lines gives frame_err=1.
- Release reset while vsync=0 and href toggling. Required: no writes until vsync pulses high then low. Drop cap_en mid-frame: the current frame completes, then no sof follows.
- Assert wrst mid-line after the first byte. Required: w_en=0 immediately, all outputs at reset values, and the next frame captures cleanly.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 write-side capture: samples the RGB565 byte stream in the PCLK domain,
// packs each pixel to RGB444 for the async FIFO, and checks line/frame geometry.
module ov7670_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CNT_W    = 10
) (
  input  logic        wclk,
  input  logic        wrst,
  input  logic        cap_en,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  d,
  input  logic        full,
  output logic        w_en,
  output logic [11:0] data_in,
  output logic        sof,
  output logic        frame_done,
  output logic        overflow,
  output logic        line_err,
  output logic        frame_err
);

  localparam logic [CNT_W-1:0] H_CNT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_CNT = CNT_W'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

  state_t           state, state_d;
  logic             ph, ph_d, ph_after;
  logic [7:0]       b1, b1_d;
  logic [CNT_W-1:0] pix_cnt, pix_cnt_d, cnt_after;
  logic [CNT_W-1:0] line_cnt, line_cnt_d, line_after;
  logic             href_q;
  logic             pix_done, line_close;
  logic             w_en_d, sof_d, frame_done_d;
  logic             overflow_d, line_err_d, frame_err_d;
  logic [11:0]      data_in_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state;
    ph_d         = ph;
    b1_d         = b1;
    pix_cnt_d    = pix_cnt;
    line_cnt_d   = line_cnt;
    w_en_d       = 1'b0;
    data_in_d    = data_in;
    sof_d        = 1'b0;
    frame_done_d = 1'b0;
    overflow_d   = overflow;
    line_err_d   = line_err;
    frame_err_d  = frame_err;
    pix_done     = 1'b0;
    line_close   = 1'b0;
    ph_after     = ph;
    cnt_after    = pix_cnt;
    line_after   = line_cnt;

    case (state)
      IDLE: begin
        if (vsync) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!vsync && cap_en) begin
          state_d    = CAPTURE;
          sof_d      = 1'b1;
          ph_d       = 1'b0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
        end
      end
      CAPTURE: begin
        pix_done = href && ph;
        if (href) ph_after = ~ph;
        if (href && !ph) b1_d = d;
        if (pix_done) begin
          cnt_after = sat_inc(pix_cnt);
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            w_en_d    = 1'b1;
            data_in_d = {b1[7:4], b1[2:0], d[7], d[4:1]};
          end
        end
        // A vsync rise while href is high closes the line as well as the frame.
        line_close = (href_q && !href) || (vsync && href);
        line_after = line_close ? sat_inc(line_cnt) : line_cnt;
        ph_d       = ph_after;
        pix_cnt_d  = cnt_after;
        line_cnt_d = line_after;
        if (line_close) begin
          if ((cnt_after != H_CNT) || ph_after) line_err_d = 1'b1;
          ph_d      = 1'b0;
          pix_cnt_d = '0;
        end
        if (vsync) begin
          frame_done_d = 1'b1;
          if (line_after != V_CNT) frame_err_d = 1'b1;
          state_d = WAIT_FRAME;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state      <= IDLE;
      ph         <= 1'b0;
      b1         <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      href_q     <= 1'b0;
      w_en       <= 1'b0;
      data_in    <= '0;
      sof        <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      ph         <= ph_d;
      b1         <= b1_d;
      pix_cnt    <= pix_cnt_d;
      line_cnt   <= line_cnt_d;
      href_q     <= href;
      w_en       <= w_en_d;
      data_in    <= data_in_d;
      sof        <= sof_d;
      frame_done <= frame_done_d;
      overflow   <= overflow_d;
      line_err   <= line_err_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule
